// File: rtl/parking_controller.sv
// Parking-lot controller: bay allocation/release, timed door pulse and derived capacity outputs.
// Optional statistics counters are enabled with the PARK_STATS_EN macro.
module parking_controller #(
    parameter int SLOTS = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int CW = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic [IW-1:0]    exit_slot,
    output logic [SLOTS-1:0] slots_occ,
    output logic             door_open,
    output logic             full_light,
    output logic [CW-1:0]    free_count,
    output logic [IW-1:0]    best_slot,
    output logic             best_valid,
    output logic             entry_ack,
    output logic             exit_err
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]      entry_total,
    output logic [15:0]      reject_total
`endif
);

    localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic {IDLE, DOOR} state_t;

    state_t         state;
    logic           entry_prev;
    logic           exit_prev;
    logic           pend_in;
    logic           pend_out;
    logic [IW-1:0]  exit_slot_q;
    logic [TW-1:0]  timer;

    logic           entry_rise;
    logic           exit_rise;
    logic           want_exit;
    logic           want_entry;
    logic           exit_ok;
    logic           do_exit;
    logic           do_entry;
    logic           refuse;
    logic [IW-1:0]  slot_sel;
    logic [SLOTS-1:0] occ_next;
    logic [CW-1:0]  free_next;
    logic [IW-1:0]  best_next;
    logic           found;

    always_comb begin
        entry_rise = entry_req & ~entry_prev;
        exit_rise  = exit_req & ~exit_prev;
        // Exit has priority; a simultaneous entry is left in its pending latch.
        want_exit  = (state == IDLE) & (pend_out | exit_rise);
        want_entry = (state == IDLE) & ~want_exit & (pend_in | entry_rise);
        slot_sel   = exit_rise ? exit_slot : exit_slot_q;
        exit_ok    = 1'b0;
        if (32'(slot_sel) < SLOTS) begin
            exit_ok = slots_occ[slot_sel];
        end
        do_exit  = want_exit & exit_ok;
        do_entry = want_entry & best_valid;
        refuse   = want_entry & ~best_valid;

        occ_next = slots_occ;
        if (do_exit) begin
            occ_next[slot_sel] = 1'b0;
        end
        if (do_entry) begin
            occ_next[best_slot] = 1'b1;
        end

        // Derived outputs follow next-state occupancy so they align with slots_occ.
        free_next = '0;
        best_next = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!occ_next[i]) begin
                free_next = free_next + CW'(1);
                if (!found) begin
                    best_next = IW'(i);
                    found     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            entry_prev  <= 1'b1;
            exit_prev   <= 1'b1;
            pend_in     <= 1'b0;
            pend_out    <= 1'b0;
            exit_slot_q <= '0;
            timer       <= '0;
            slots_occ   <= '0;
            door_open   <= 1'b0;
            full_light  <= 1'b0;
            free_count  <= CW'(SLOTS);
            best_slot   <= '0;
            best_valid  <= 1'b1;
            entry_ack   <= 1'b0;
            exit_err    <= 1'b0;
        end else begin
            entry_prev <= entry_req;
            exit_prev  <= exit_req;
            if (exit_rise) begin
                exit_slot_q <= exit_slot;
            end
            pend_out <= (pend_out | exit_rise) & ~want_exit;
            pend_in  <= (pend_in | entry_rise) & ~want_entry;

            entry_ack  <= do_entry;
            exit_err   <= want_exit & ~exit_ok;
            slots_occ  <= occ_next;
            free_count <= free_next;
            best_slot  <= best_next;
            best_valid <= found;

            if (refuse) begin
                full_light <= 1'b1;
            end else if (!entry_req || do_exit) begin
                full_light <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (do_exit || do_entry) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        timer     <= TW'(DOOR_CYCLES - 1);
                    end
                end
                DOOR: begin
                    if (timer == '0) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_total  <= '0;
            reject_total <= '0;
        end else begin
            if (do_entry && (entry_total != '1)) begin
                entry_total <= entry_total + 16'd1;
            end
            if (refuse && (reject_total != '1)) begin
                reject_total <= reject_total + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_parking_controller.sv
// Self-checking bench for parking_controller (SLOTS=4, DOOR_CYCLES=8), table-driven with a scoreboard queue.
module tb_parking_controller;
    localparam int SLOTS = 4;
    localparam int DOOR_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_slot;
    logic [3:0] slots_occ;
    logic       door_open;
    logic       full_light;
    logic [2:0] free_count;
    logic [1:0] best_slot;
    logic       best_valid;
    logic       entry_ack;
    logic       exit_err;
`ifdef PARK_STATS_EN
    logic [15:0] entry_total;
    logic [15:0] reject_total;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parking_controller #(.SLOTS(SLOTS), .DOOR_CYCLES(DOOR_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .exit_slot  (exit_slot),
        .slots_occ  (slots_occ),
        .door_open  (door_open),
        .full_light (full_light),
        .free_count (free_count),
        .best_slot  (best_slot),
        .best_valid (best_valid),
        .entry_ack  (entry_ack),
        .exit_err   (exit_err)
`ifdef PARK_STATS_EN
        ,
        .entry_total  (entry_total),
        .reject_total (reject_total)
`endif
    );

    typedef struct {
        logic       ent;
        logic       ext;
        logic [1:0] slot;
        logic [3:0] occ;
        logic       ack;
        logic       err;
        logic       full;
        logic [2:0] free;
        logic [1:0] best;
        logic       valid;
        int         door;
    } vec_t;

    vec_t q[$];
    vec_t tbl[12];

    function automatic vec_t mk(input logic ent, input logic ext, input logic [1:0] slot,
                                input logic [3:0] occ, input logic ack, input logic err,
                                input logic full, input logic [2:0] free, input logic [1:0] best,
                                input logic valid, input int door);
        vec_t v;
        v.ent = ent; v.ext = ext; v.slot = slot; v.occ = occ; v.ack = ack; v.err = err;
        v.full = full; v.free = free; v.best = best; v.valid = valid; v.door = door;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic door_width(input string name, input int exp_w);
        int cnt;
        cnt = 0;
        while (door_open && cnt < 100) begin
            cnt++;
            tick();
        end
        check(name, cnt, exp_w);
    endtask

    task automatic apply(input vec_t t);
        vec_t e;
        entry_req = t.ent;
        exit_req  = t.ext;
        exit_slot = t.slot;
        q.push_back(t);
        tick();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        e = q.pop_front();
        check("occ", slots_occ, e.occ);
        check("entry_ack", entry_ack, e.ack);
        check("exit_err", exit_err, e.err);
        check("full_light", full_light, e.full);
        check("free_count", free_count, e.free);
        check("best_slot", best_slot, e.best);
        check("best_valid", best_valid, e.valid);
        check("door_start", door_open, e.door != 0);
        door_width("door_width", e.door);
        tick();
        check("pulses_clear", {entry_ack, exit_err}, 2'b00);
        check("full_cleared", full_light, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 3'd3, 2'd1, 1'b1, 8);
        tbl[1]  = mk(1'b1, 1'b0, 2'd0, 4'b0011, 1'b1, 1'b0, 1'b0, 3'd2, 2'd2, 1'b1, 8);
        tbl[2]  = mk(1'b1, 1'b0, 2'd0, 4'b0111, 1'b1, 1'b0, 1'b0, 3'd1, 2'd3, 1'b1, 8);
        tbl[3]  = mk(1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 8);
        tbl[4]  = mk(1'b1, 1'b0, 2'd0, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 0);
        tbl[5]  = mk(1'b0, 1'b1, 2'd1, 4'b1101, 1'b0, 1'b0, 1'b0, 3'd1, 2'd1, 1'b1, 8);
        tbl[6]  = mk(1'b0, 1'b1, 2'd1, 4'b1101, 1'b0, 1'b1, 1'b0, 3'd1, 2'd1, 1'b1, 0);
        tbl[7]  = mk(1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 8);
        tbl[8]  = mk(1'b0, 1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 8);
        tbl[9]  = mk(1'b0, 1'b1, 2'd3, 4'b0110, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 1'b1, 8);
        tbl[10] = mk(1'b1, 1'b0, 2'd0, 4'b0111, 1'b1, 1'b0, 1'b0, 3'd1, 2'd3, 1'b1, 8);
        tbl[11] = mk(1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 8);

        // Reset with the entry sensor held high across release.
        rst_n = 1'b0;
        entry_req = 1'b1;
        exit_req = 1'b0;
        exit_slot = 2'd0;
        tick();
        tick();
        check("rst_occ", slots_occ, 4'b0000);
        check("rst_door", door_open, 1'b0);
        check("rst_full", full_light, 1'b0);
        check("rst_ack", entry_ack, 1'b0);
        check("rst_err", exit_err, 1'b0);
        check("rst_free", free_count, 3'd4);
        check("rst_best", best_slot, 2'd0);
        check("rst_valid", best_valid, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("held_entry_ack", entry_ack, 1'b0);
            check("held_entry_occ", slots_occ, 4'b0000);
            check("held_entry_door", door_open, 1'b0);
        end
        entry_req = 1'b0;
        tick();

        foreach (tbl[i]) apply(tbl[i]);

        // Entry and exit rising together while full: exit first, entry afterwards.
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 2'd2;
        tick();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        check("sim_occ", slots_occ, 4'b1011);
        check("sim_ack", entry_ack, 1'b0);
        check("sim_free", free_count, 3'd1);
        check("sim_best", best_slot, 2'd2);
        door_width("sim_door1", 8);
        check("sim_gap_ack", entry_ack, 1'b0);
        tick();
        check("sim_occ2", slots_occ, 4'b1111);
        check("sim_ack2", entry_ack, 1'b1);
        check("sim_door2", door_open, 1'b1);
        check("sim_free2", free_count, 3'd0);
        door_width("sim_door2_width", 8);
        tick();

        // Asynchronous reset in the middle of a door pulse.
        exit_req  = 1'b1;
        exit_slot = 2'd0;
        tick();
        exit_req = 1'b0;
        check("pre_rst_door", door_open, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_door", door_open, 1'b0);
        check("async_rst_occ", slots_occ, 4'b0000);
        check("async_rst_free", free_count, 3'd4);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef PARK_STATS_EN
        for (int i = 0; i < 4; i++) apply(tbl[i]);
        apply(tbl[4]);
        apply(tbl[4]);
        check("entry_total", entry_total, 16'd4);
        check("reject_total", reject_total, 16'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
